// File: rtl/im2_irq_source.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | im2_irq_source                                                           |
// | 8-channel edge-latched interrupt source with Z80 IM2 nesting and RETI.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module im2_irq_source #(
   parameter int NCH         = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic           CLK,
   input  logic           nCPUxRESET,
   input  logic [NCH-1:0] EVT,
   input  logic [1:0]     CPU_ADDR,
   input  logic [7:0]     CPU_D,
   input  logic           nCSxIRQ,
   input  logic           nCPUxRD,
   input  logic           nCPUxWR,
   input  logic           nCPUxM1,
   input  logic           nCPUxIORQ,
   input  logic           nCPUxMREQ,
   output logic [7:0]     D_OUT,
   output logic           D_OE,
   output logic [NCH-1:0] EIRQ,
   output logic           IRQ_ACTIVE
);

   localparam logic [7:0] c_opEd = 8'hED;
   localparam logic [7:0] c_op4d = 8'h4D;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      SAW_ED = 1'b1
   } retiState_t;

   logic [NCH-1:0] r_sync [SYNC_STAGES];
   logic [NCH-1:0] r_evtHist;
   logic [NCH-1:0] r_pending;
   logic [NCH-1:0] r_mask;
   logic [NCH-1:0] r_insvc;
   logic [NCH-1:0] r_pol;
   logic           r_wrStbD;
   logic           r_intaD;
   logic           r_fetchD;
   logic [7:0]     r_opcode;
   retiState_t     r_state;

   logic [NCH-1:0] w_evtSync;
   logic [NCH-1:0] w_evtEdge;
   logic [NCH-1:0] w_allow;
   logic [NCH-1:0] w_eirq;
   logic [NCH-1:0] w_served;
   logic [NCH-1:0] w_topInsvc;
   logic [NCH-1:0] w_pendClr;
   logic [NCH-1:0] w_intaSet;
   logic [NCH-1:0] w_retireClr;
   logic           w_wrStb;
   logic           w_wrEvt;
   logic           w_intaStb;
   logic           w_intaEvt;
   logic           w_fetch;
   logic           w_fetchDone;
   logic           w_reti;
   retiState_t     w_stateNext;

   always_ff @(posedge CLK or negedge nCPUxRESET) begin
      if (!nCPUxRESET) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
         r_evtHist <= '0;
      end else begin
         r_sync[0] <= EVT;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
         r_evtHist <= r_sync[SYNC_STAGES-1];
      end
   end

   // Edge polarity is applied to the raw flop pair, so rewriting POL never fakes an event.
   assign w_evtSync = r_sync[SYNC_STAGES-1];
   assign w_evtEdge = (~r_pol & w_evtSync & ~r_evtHist) | (r_pol & ~w_evtSync & r_evtHist);

   assign w_wrStb   = ~nCSxIRQ & ~nCPUxIORQ & ~nCPUxWR & nCPUxM1;
   assign w_wrEvt   = w_wrStb & ~r_wrStbD;
   assign w_intaStb = ~nCPUxM1 & ~nCPUxIORQ;
   assign w_intaEvt = w_intaStb & ~r_intaD;
   assign w_fetch   = ~nCPUxM1 & ~nCPUxMREQ & ~nCPUxRD;
   assign w_fetchDone = r_fetchD & nCPUxRD;

   // A channel qualifies only if no in-service bit sits at or above it.
   always_comb begin
      w_allow = '0;
      for (int i = 0; i < NCH; i++) w_allow[i] = ~|(r_insvc >> i);
   end

   assign w_eirq = r_pending & r_mask & w_allow;

   always_comb begin
      w_served   = '0;
      w_topInsvc = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_eirq[i]) begin
            w_served    = '0;
            w_served[i] = 1'b1;
         end
         if (r_insvc[i]) begin
            w_topInsvc    = '0;
            w_topInsvc[i] = 1'b1;
         end
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_reti      = 1'b0;
      if (w_fetchDone) begin
         case (r_state)
            IDLE: begin
               if (r_opcode == c_opEd) w_stateNext = SAW_ED;
            end
            SAW_ED: begin
               if (r_opcode != c_opEd) begin
                  w_stateNext = IDLE;
                  w_reti      = (r_opcode == c_op4d);
               end
            end
            default: w_stateNext = IDLE;
         endcase
      end
   end

   assign w_intaSet   = w_intaEvt ? w_served : '0;
   assign w_retireClr = w_reti ? w_topInsvc : '0;
   assign w_pendClr   = ((w_wrEvt && CPU_ADDR == 2'd0) ? CPU_D[NCH-1:0] : '0) | w_intaSet;

   always_ff @(posedge CLK or negedge nCPUxRESET) begin
      if (!nCPUxRESET) begin
         r_pending <= '0;
         r_mask    <= '0;
         r_insvc   <= '0;
         r_pol     <= '0;
         r_wrStbD  <= 1'b0;
         r_intaD   <= 1'b0;
         r_fetchD  <= 1'b0;
         r_opcode  <= '0;
         r_state   <= IDLE;
      end else begin
         r_pending <= (r_pending & ~w_pendClr) | w_evtEdge;
         r_insvc   <= (r_insvc | w_intaSet) & ~w_retireClr;
         if (w_wrEvt && CPU_ADDR == 2'd1) r_mask <= CPU_D[NCH-1:0];
         if (w_wrEvt && CPU_ADDR == 2'd3) r_pol  <= CPU_D[NCH-1:0];
         r_wrStbD <= w_wrStb;
         r_intaD  <= w_intaStb;
         r_fetchD <= w_fetch;
         if (w_fetch) r_opcode <= CPU_D;
         r_state  <= w_stateNext;
      end
   end

   assign D_OE       = ~nCSxIRQ & ~nCPUxIORQ & ~nCPUxRD & nCPUxM1;
   assign EIRQ       = w_eirq;
   assign IRQ_ACTIVE = |r_insvc;

   always_comb begin
      D_OUT = '0;
      if (D_OE) begin
         case (CPU_ADDR)
            2'd0:    D_OUT = r_pending;
            2'd1:    D_OUT = r_mask;
            2'd2:    D_OUT = r_insvc;
            default: D_OUT = r_pol;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_im2_irq_source.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_im2_irq_source                                                        |
// | Directed bus/event stimulus with a queued-expectation monitor.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_im2_irq_source;

   logic       CLK = 1'b0;
   logic       nCPUxRESET = 1'b0;
   logic [7:0] EVT = '0;
   logic [1:0] CPU_ADDR = '0;
   logic [7:0] CPU_D = '0;
   logic       nCSxIRQ = 1'b1, nCPUxRD = 1'b1, nCPUxWR = 1'b1;
   logic       nCPUxM1 = 1'b1, nCPUxIORQ = 1'b1, nCPUxMREQ = 1'b1;
   logic [7:0] D_OUT;
   logic       D_OE;
   logic [7:0] EIRQ;
   logic       IRQ_ACTIVE;

   im2_irq_source #(.NCH(8), .SYNC_STAGES(2)) dut (
      .CLK(CLK), .nCPUxRESET(nCPUxRESET), .EVT(EVT), .CPU_ADDR(CPU_ADDR), .CPU_D(CPU_D),
      .nCSxIRQ(nCSxIRQ), .nCPUxRD(nCPUxRD), .nCPUxWR(nCPUxWR), .nCPUxM1(nCPUxM1),
      .nCPUxIORQ(nCPUxIORQ), .nCPUxMREQ(nCPUxMREQ), .D_OUT(D_OUT), .D_OE(D_OE),
      .EIRQ(EIRQ), .IRQ_ACTIVE(IRQ_ACTIVE)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string      name;
      bit         isRead;
      logic [7:0] data;
      logic [7:0] eirq;
      logic       act;
   } exp_t;

   exp_t q[$];
   exp_t monE;
   int   checks = 0;
   int   failures = 0;
   logic probe = 1'b0;
   logic prevOe = 1'b0;

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Monitor: one comparison set per read cycle (D_OE rise) or per probe strobe.
   always @(negedge CLK) begin
      if ((D_OE && !prevOe) || probe) begin
         if (q.size() == 0) begin
            chk("unexpected_output", 8'h01, 8'h00);
         end else begin
            monE = q.pop_front();
            if (monE.isRead) chk({monE.name, ".dout"}, D_OUT, monE.data);
            chk({monE.name, ".eirq"}, EIRQ, monE.eirq);
            chk({monE.name, ".active"}, {7'd0, IRQ_ACTIVE}, {7'd0, monE.act});
         end
      end
      prevOe <= D_OE;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic busIdle();
      nCSxIRQ = 1'b1; nCPUxRD = 1'b1; nCPUxWR = 1'b1;
      nCPUxM1 = 1'b1; nCPUxIORQ = 1'b1; nCPUxMREQ = 1'b1;
   endtask

   task automatic ioWrite(input logic [1:0] a, input logic [7:0] d);
      CPU_ADDR = a; CPU_D = d; nCSxIRQ = 1'b0; nCPUxIORQ = 1'b0; nCPUxWR = 1'b0;
      tick(3);
      busIdle();
      tick(1);
   endtask

   task automatic ioRead(input string name, input logic [1:0] a, input logic [7:0] d,
                         input logic [7:0] e, input logic act);
      exp_t x;
      x.name = name; x.isRead = 1'b1; x.data = d; x.eirq = e; x.act = act;
      q.push_back(x);
      CPU_ADDR = a; nCSxIRQ = 1'b0; nCPUxIORQ = 1'b0; nCPUxRD = 1'b0;
      tick(2);
      busIdle();
      tick(1);
   endtask

   task automatic doProbe(input string name, input logic [7:0] e, input logic act);
      exp_t x;
      x.name = name; x.isRead = 1'b0; x.data = '0; x.eirq = e; x.act = act;
      q.push_back(x);
      probe = 1'b1;
      @(negedge CLK);
      #1 probe = 1'b0;
   endtask

   task automatic fetch(input logic [7:0] op);
      CPU_D = op; nCPUxM1 = 1'b0; nCPUxMREQ = 1'b0; nCPUxRD = 1'b0;
      tick(2);
      busIdle();
      tick(1);
   endtask

   task automatic memRead(input logic [7:0] op);
      CPU_D = op; nCPUxMREQ = 1'b0; nCPUxRD = 1'b0;
      tick(2);
      busIdle();
      tick(1);
   endtask

   task automatic inta();
      nCPUxM1 = 1'b0; nCPUxIORQ = 1'b0;
      tick(2);
      busIdle();
      tick(1);
   endtask

   task automatic pulse(input int ch);
      EVT[ch] = 1'b1;
      tick(5);
      EVT[ch] = 1'b0;
      tick(5);
   endtask

   initial begin
      tick(3);
      nCPUxRESET = 1'b1;
      tick(1);
      ioRead("rst_pend", 2'd0, 8'h00, 8'h00, 1'b0);
      ioRead("rst_mask", 2'd1, 8'h00, 8'h00, 1'b0);
      ioRead("rst_insvc", 2'd2, 8'h00, 8'h00, 1'b0);
      ioRead("rst_pol", 2'd3, 8'h00, 8'h00, 1'b0);

      // Latency: request appears on the third edge after sampling.
      ioWrite(2'd1, 8'hFF);
      EVT[3] = 1'b1;
      tick(1); doProbe("lat_edge1", 8'h00, 1'b0);
      tick(1); doProbe("lat_edge2", 8'h00, 1'b0);
      tick(1); doProbe("lat_edge3", 8'h08, 1'b0);
      EVT[3] = 1'b0;
      tick(5);
      ioRead("ch3_pend", 2'd0, 8'h08, 8'h08, 1'b0);

      // Nesting
      inta();
      ioRead("inta3_insvc", 2'd2, 8'h08, 8'h00, 1'b1);
      ioRead("inta3_pend", 2'd0, 8'h00, 8'h00, 1'b1);
      pulse(1);
      ioRead("low_blocked", 2'd0, 8'h02, 8'h00, 1'b1);
      pulse(5);
      ioRead("high_passes", 2'd0, 8'h22, 8'h20, 1'b1);
      inta();
      ioRead("inta5_insvc", 2'd2, 8'h28, 8'h00, 1'b1);

      // RETI decode
      fetch(8'hED); fetch(8'h4D);
      ioRead("reti_1", 2'd2, 8'h08, 8'h00, 1'b1);
      fetch(8'hED); fetch(8'h00); fetch(8'h4D);
      ioRead("reti_broken", 2'd2, 8'h08, 8'h00, 1'b1);
      fetch(8'hED); fetch(8'hED); fetch(8'h4D);
      ioRead("reti_eded", 2'd2, 8'h00, 8'h02, 1'b0);
      inta();
      fetch(8'hED); memRead(8'h4D);
      ioRead("reti_memrd", 2'd2, 8'h02, 8'h00, 1'b1);
      fetch(8'h4D);
      ioRead("reti_after_nonm1", 2'd2, 8'h00, 8'h00, 1'b0);

      // Masking
      ioWrite(2'd1, 8'h00);
      pulse(6);
      ioRead("masked_pend", 2'd0, 8'h40, 8'h00, 1'b0);
      ioWrite(2'd1, 8'h40);
      ioRead("unmask", 2'd1, 8'h40, 8'h40, 1'b0);
      ioWrite(2'd0, 8'h40);
      ioRead("w1c", 2'd0, 8'h00, 8'h00, 1'b0);

      // Polarity
      ioWrite(2'd3, 8'h01);
      ioWrite(2'd1, 8'hFF);
      ioRead("pol_rd", 2'd3, 8'h01, 8'h00, 1'b0);
      EVT[0] = 1'b1; tick(5);
      ioRead("pol_rise_ignored", 2'd0, 8'h00, 8'h00, 1'b0);
      EVT[0] = 1'b0; tick(5);
      ioRead("pol_fall", 2'd0, 8'h01, 8'h01, 1'b0);
      ioWrite(2'd0, 8'h01);

      // Event and W1C on the same edge
      EVT[4] = 1'b1;
      tick(2);
      ioWrite(2'd0, 8'h10);
      ioRead("race_w1c", 2'd0, 8'h10, 8'h10, 1'b0);
      EVT[4] = 1'b0; tick(5);
      ioWrite(2'd0, 8'h10);

      // Event on the channel being acknowledged
      pulse(2);
      EVT[2] = 1'b1;
      tick(2);
      inta();
      ioRead("race_inta_insvc", 2'd2, 8'h04, 8'h00, 1'b1);
      ioRead("race_inta_pend", 2'd0, 8'h04, 8'h00, 1'b1);
      EVT[2] = 1'b0; tick(5);
      fetch(8'hED); fetch(8'h4D);
      ioWrite(2'd0, 8'h04);
      ioRead("race_clean", 2'd0, 8'h00, 8'h00, 1'b0);

      // Async reset during ED/4D
      pulse(7);
      inta();
      pulse(3);
      fetch(8'hED); fetch(8'h45);
      ioRead("retn", 2'd2, 8'h80, 8'h00, 1'b1);
      fetch(8'hED);
      CPU_D = 8'h4D; nCPUxM1 = 1'b0; nCPUxMREQ = 1'b0; nCPUxRD = 1'b0;
      tick(1);
      #1 nCPUxRESET = 1'b0;
      doProbe("rst_async", 8'h00, 1'b0);
      busIdle();
      tick(1);
      ioRead("rst_mid_mask", 2'd1, 8'h00, 8'h00, 1'b0);
      ioRead("rst_mid_insvc", 2'd2, 8'h00, 8'h00, 1'b0);
      ioRead("rst_mid_pend", 2'd0, 8'h00, 8'h00, 1'b0);
      ioRead("rst_mid_pol", 2'd3, 8'h00, 8'h00, 1'b0);
      #2 nCPUxRESET = 1'b1;
      tick(1);
      ioWrite(2'd1, 8'hFF);
      pulse(6);
      inta();
      fetch(8'h4D);
      ioRead("lone_4d", 2'd2, 8'h40, 8'h00, 1'b1);

      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge CLK);
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expectations expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
